// File: rtl/rr_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_sel_arbiter
// Brief   : 8-requester round-robin arbiter with a registered 3-bit grant
//           index, grant-valid flag, hold-time limit and rotating priority
//           pointer. Drives a downstream 3:8 one-hot decoder.
// Revision: 1.0 - initial release
// ============================================================================
module rr_sel_arbiter #(
   parameter int unsigned IDX_W    = 3,   // only 3 is supported (3:8 decoder)
   parameter int unsigned MAX_HOLD = 16   // 0 disables the timeout, 0..255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [(1 << IDX_W)-1:0]     req,
   input  logic                        release_i,
   output logic [IDX_W-1:0]            grant_idx,
   output logic                        grant_valid,
   output logic                        timeout_o,
   output logic [IDX_W-1:0]            ptr_o
);

   localparam int unsigned      N          = 1 << IDX_W;
   localparam int unsigned      CNT_W      = 8;
   localparam logic             TIMEOUT_EN = (MAX_HOLD != 0);
   // Last hold count before a forced revoke; unused when the timeout is off.
   localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t             state_q,       state_d;
   logic [IDX_W-1:0]   grant_idx_q,   grant_idx_d;
   logic               grant_valid_q, grant_valid_d;
   logic               timeout_q,     timeout_d;
   logic [IDX_W-1:0]   ptr_q,         ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q,    hold_cnt_d;

   logic [N-1:0]       req_rot;
   logic [IDX_W-1:0]   sel_off;
   logic [IDX_W-1:0]   sel_idx;
   logic               any_req;
   logic               owner_req;

   // Rotate the request vector so bit 0 is the pointer position, then pick
   // the lowest set bit; the index sum wraps naturally modulo N.
   always_comb begin
      req_rot = '0;
      sel_off = '0;
      for (int k = 0; k < N; k++) begin
         req_rot[k] = req[ptr_q + IDX_W'(k)];
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            sel_off = IDX_W'(k);
         end
      end
      sel_idx   = ptr_q + sel_off;
      any_req   = |req;
      owner_req = req[grant_idx_q];
   end

   // Next-state logic: grant from IDLE, and decide exit/hold/timeout in GRANT.
   always_comb begin
      state_d       = state_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      timeout_d     = 1'b0;
      ptr_d         = ptr_q;
      hold_cnt_d    = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_idx_d   = sel_idx;
               grant_valid_d = 1'b1;
               hold_cnt_d    = '0;
               state_d       = ST_GRANT;
            end else begin
               grant_valid_d = 1'b0;
            end
         end

         ST_GRANT: begin
            // Release beats a withdrawn request, which beats the timeout.
            if (release_i || !owner_req) begin
               grant_valid_d = 1'b0;
               ptr_d         = grant_idx_q + IDX_ONE;
               state_d       = ST_IDLE;
            end else if (TIMEOUT_EN && (hold_cnt_q == HOLD_LAST)) begin
               grant_valid_d = 1'b0;
               timeout_d     = 1'b1;
               ptr_d         = grant_idx_q + IDX_ONE;
               state_d       = ST_IDLE;
            end else if (hold_cnt_q != CNT_MAX) begin
               // Saturating so a disabled timeout never wraps the counter.
               hold_cnt_d    = hold_cnt_q + CNT_ONE;
            end
         end

         default: begin
            grant_valid_d = 1'b0;
            state_d       = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
         ptr_q         <= '0;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
         ptr_q         <= ptr_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign timeout_o   = timeout_q;
   assign ptr_o       = ptr_q;

endmodule
`default_nettype wire

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- 8-requester round-robin arbiter that produces a registered 3-bit grant index plus a valid flag.
- Sits directly upstream of the team's 3:8 one-hot decoder, which expands grant_idx into per-requester enable lines.
- Holds each grant until the requester releases, drops its request, or hits a hold-time limit. Fairness comes from a rotating priority pointer.

Parameters:
- IDX_W, 3, index width; requester count N = 2**IDX_W = 8. Only 3 is supported, to match the downstream 3:8 decoder.
- MAX_HOLD, 16, maximum cycles a grant may be held. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit i = requester i
- release_i  input  1  single-cycle pulse from the current owner ending its grant
- grant_idx  output  3  index of the current owner; fed to the 3:8 decoder
- grant_valid  output  1  high while grant_idx names a valid owner
- timeout_o  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD
- ptr_o  output  3  current round-robin priority pointer (debug/visibility)

Behaviour:
- Reset (async assert; deassert is synchronised by the system):
  - grant_idx=0, grant_valid=0, timeout_o=0, ptr_o=0
  - hold counter=0, state=IDLE
- FSM states: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req != 0 at a rising edge, select the first set bit searching ptr, ptr+1, … mod 8.
  - Load that index into grant_idx, set grant_valid=1 and hold_cnt=0, go to GRANT.
  - Latency: req sampled at edge t gives grant_valid=1 immediately after edge t (1 cycle).
  - If req == 0, stay in IDLE; outputs are unchanged except grant_valid=0.
- GRANT: at each edge, evaluate the exit conditions in this priority order:
  1. release_i=1 → normal exit.
  2. req[grant_idx]=0 → normal exit (requester withdrew).
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 → timeout exit; timeout_o=1 for exactly that next cycle.
  4. Otherwise hold_cnt += 1, stay in GRANT. hold_cnt saturates; it never wraps while in GRANT.
- Any exit:
  - grant_valid←0, ptr←(grant_idx+1) mod 8 (wraps 7→0), state←IDLE.
  - grant_idx keeps its last value while grant_valid=0; the decoder output must be qualified with grant_valid downstream.
- Mandatory bubble: at least one cycle with grant_valid=0 between consecutive grants, even with continuous requests. Back-to-back grants are therefore 2 cycles apart minimum.
- release_i in IDLE is ignored. release_i and timeout in the same cycle: release wins and timeout_o stays 0.
- Requests from non-owners during GRANT are ignored until the next IDLE evaluation. Requests are level-sensitive; no request is latched.
- With all 8 requesting continuously, the grant sequence is strictly 0,1,2,…,7,0… starting from the reset pointer.
- A single requester repeatedly requesting is re-granted every 2 cycles (pointer wrap lands back on it).
- Reset mid-GRANT: outputs return asynchronously to reset values. No timeout_o pulse. Pointer goes to 0.
- No combinational path from req/release_i to any output.

Test Plan:
- Reset, then req=8'b0000_0100 held; release_i pulse on 3rd grant cycle → grant_idx=2, grant_valid=1 one cycle after the req edge, stays 3 cycles, then 0; ptr_o=3.
- req=8'hFF held, release_i pulsed each grant cycle → grant_idx sequence 0,1,2,3,4,5,6,7,0 with grant_valid toggling 1,0,1,0…; ptr wraps 7→0.
- ptr=5 (after granting 4), req=8'b0010_0001 → grant_idx=5. Next round req=8'b0000_0001 → grant_idx=0 (wrap search).
- MAX_HOLD=16, req=8'b1000_0000 held, no release → grant_valid high exactly 16 cycles, timeout_o=1 for one cycle as grant_valid falls, re-grant to 7 after one bubble.
- Owner 3 drops req[3] mid-grant while req[6]=1 → grant_valid falls next edge, 1 bubble, then grant_idx=6; timeout_o stays 0.
- Assert rst during GRANT (grant_idx=4, hold_cnt=9) → all outputs 0 immediately without waiting for clk. After rst release with req=8'h10, grant_idx=4 granted from ptr=0.
